// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display driver.
//   SEG_OFF : all segments dark (active-low encoding)
//   HEX7    : nibble -> active-low {g,f,e,d,c,b,a} pattern
//   hex7()  : table lookup helper
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return HEX7[nib];
  endfunction

endpackage

// File: rtl/seven_seg_mux_hex7_decode.sv
// Combinational hex nibble to seven-segment decoder.
//   nib_i : hex digit 0..F
//   seg_o : active-low segments {g,f,e,d,c,b,a}
module hex7_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex7(nib_i);

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Captures a packed hex word into shadow registers on load and scans one digit
// per refresh slot, with per-digit decimal point, blanking, leading-zero
// suppression and PWM brightness.
//   clk, reset   : clock, synchronous active-high reset
//   load         : capture value / dp_in / blank_in into shadows
//   value        : hex nibbles, digit 0 rightmost
//   dp_in        : per-digit decimal point enable
//   blank_in     : per-digit force dark
//   lz_blank     : suppress leading zeros
//   en           : anode enable (counters keep running when low)
//   bright       : PWM duty, digit lit while pwm count <= bright
//   seg, dp, an  : active-low segment, decimal point and anode pins
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BR_BITS     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_blank,
  input  logic                    en,
  input  logic [BR_BITS-1:0]      bright,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    gap_q, gap_d;
  logic [BR_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    tick;
  logic [3:0]              nib_sel;
  logic [6:0]              seg_dec;
  logic [NUM_DIGITS-1:0]   lzb;
  logic                    lit;

  assign tick = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));

  // Counters and shadows
  always_comb begin
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    idx_d      = idx_q;
    gap_d      = 1'b0;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      gap_d = 1'b1;
    end
    pwm_cnt_d  = pwm_cnt_q + BR_BITS'(1);
    sh_value_d = load ? value    : sh_value_q;
    sh_dp_d    = load ? dp_in    : sh_dp_q;
    sh_blank_d = load ? blank_in : sh_blank_q;
  end

  // A digit is zero-suppressed only if it and every more significant digit
  // are zero; digit 0 always shows.
  always_comb begin
    logic all_zero;
    lzb      = '0;
    all_zero = lz_blank;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (sh_value_q[4*i +: 4] == 4'h0);
      lzb[i]   = all_zero;
    end
  end

  assign nib_sel = sh_value_q[{idx_q, 2'b00} +: 4];

  hex7_decode u_dec (
    .nib_i (nib_sel),
    .seg_o (seg_dec)
  );

  // Output stage: decoded from the current scan state, registered onto the pins.
  always_comb begin
    lit   = en & ~gap_q & ~sh_blank_q[idx_q] & (pwm_cnt_q <= bright);
    an_d  = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d = (sh_blank_q[idx_q] | lzb[idx_q]) ? SEG_OFF : seg_dec;
    dp_d  = ~(sh_dp_q[idx_q] & ~sh_blank_q[idx_q]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q  <= '0;
      idx_q      <= '0;
      gap_q      <= 1'b0;
      pwm_cnt_q  <= '0;
      sh_value_q <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '1;
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      pwm_cnt_q  <= pwm_cnt_d;
      sh_value_q <= sh_value_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
module tb_seven_seg_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_blank = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  bright = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int total = 0;
  int bad = 0;
  int n = 0;

  seven_seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BR_BITS(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .value    (value),
    .dp_in    (dp_in),
    .blank_in (blank_in),
    .lz_blank (lz_blank),
    .en       (en),
    .bright   (bright),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"},  {28'h0, an}, 32'hF);
    chk({tag, "_seg"}, {25'h0, seg}, 32'h7F);
    chk({tag, "_dp"},  {31'h0, dp}, 32'h1);
  endtask

  // One reset edge, then a load edge with the given display contents.
  // Afterwards n counts edges since the reset edge (load edge is n=1).
  task automatic restart_and_load(input logic [15:0] v, input logic [3:0] dpi,
                                  input logic [3:0] bl);
    reset = 1'b1;
    load  = 1'b0;
    step();
    n     = 0;
    reset = 1'b0;
    value = v;
    dp_in = dpi;
    blank_in = bl;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Pins after edge n reflect the scan state left by edge n-1:
  //   s = n-1, div = s%4, digit = (s/4)%4, gap on s%4==0 (s>=4), pwm = s%8.
  task automatic run_scan(input string tag, input int count, input logic [27:0] segs,
                          input logic [3:0] dp_exp, input logic [3:0] lit_mask,
                          input int br, input logic en_e);
    for (int c = 0; c < count; c++) begin
      int s;
      int d;
      logic g;
      logic [3:0] ea;
      step();
      s  = n - 1;
      d  = (s / 4) % 4;
      g  = (s >= 4) && (s % 4 == 0);
      ea = (en_e && !g && lit_mask[d] && ((s % 8) <= br)) ? ~(4'b0001 << d) : 4'hF;
      chk({tag, "_an"},  {28'h0, an},  {28'h0, ea});
      chk({tag, "_seg"}, {25'h0, seg}, {25'h0, segs[7*d +: 7]});
      chk({tag, "_dp"},  {31'h0, dp},  {31'h0, dp_exp[d]});
    end
  endtask

  initial begin
    // 1. reset held for three cycles, then idle with nothing loaded
    reset = 1'b1;
    en = 1'b1;
    bright = 3'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_dark("reset_hold");
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_dark("no_load");
    end

    // 2. basic scan of 12AF: digits F,A,2,1
    lz_blank = 1'b0;
    restart_and_load(16'h12AF, 4'b0000, 4'b0000);
    run_scan("scan_12AF", 32, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'hF, 7, 1'b1);

    // value change without load never reaches the pins
    value = 16'h0000;
    run_scan("no_load_chg", 8, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'hF, 7, 1'b1);

    // 3. leading-zero suppression
    lz_blank = 1'b1;
    restart_and_load(16'h0040, 4'b0000, 4'b0000);
    run_scan("lz_0040", 16, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'hF, 4'hF, 7, 1'b1);
    restart_and_load(16'h0000, 4'b0000, 4'b0000);
    run_scan("lz_0000", 16, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 4'hF, 7, 1'b1);
    // interior zero is not suppressed
    restart_and_load(16'h0305, 4'b0000, 4'b0000);
    run_scan("lz_0305", 16, {7'h7F, 7'h30, 7'h40, 7'h12}, 4'hF, 4'hF, 7, 1'b1);
    lz_blank = 1'b0;

    // 4. brightness and enable
    bright = 3'd0;
    restart_and_load(16'h12AF, 4'b0000, 4'b0000);
    run_scan("bright0", 16, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'hF, 0, 1'b1);
    bright = 3'd4;
    restart_and_load(16'h12AF, 4'b0000, 4'b0000);
    run_scan("bright4", 16, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'hF, 4, 1'b1);
    bright = 3'd7;
    en = 1'b0;
    restart_and_load(16'h12AF, 4'b0000, 4'b0000);
    run_scan("en0", 16, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'hF, 7, 1'b0);
    en = 1'b1;

    // 5. per-digit blank and decimal points
    restart_and_load(16'h12AF, 4'b0011, 4'b0010);
    run_scan("blank_dp", 18, {7'h79, 7'h24, 7'h7F, 7'h0E}, 4'b1110, 4'b1101, 7, 1'b1);

    // 6. reset mid-slot overrides a simultaneous load
    reset = 1'b1;
    load = 1'b1;
    value = 16'hFFFF;
    blank_in = 4'b0000;
    dp_in = 4'b1111;
    step();
    chk_dark("reset_mid");
    reset = 1'b0;
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_dark("after_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
